// File: rtl/axi_ad7124_up_axi_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for the AD7124 AXI4-Lite to up_* bridge.
//
// axi_ad7124_up_axi_if : AXI4-Lite channel set (AW, W, B, AR, R).
//   slave modport  - the bridge side (accepts addresses/data, returns B/R).
//   master modport - the initiator side.
// axi_ad7124_up_bus_if : up_* register bus towards the per-board address map.
//   master modport - the bridge side (issues up_wreq/up_rreq, holds addresses).
//   slave modport  - the register map side (returns up_wack/up_rack/up_rdata).
// Member names keep the full s_axi_* / up_* prefixes so they line up with the
// register-map sources that consume them.
// ---------------------------------------------------------------------------
interface axi_ad7124_up_axi_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [ADDR_WIDTH+1:0]   s_axi_awaddr;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [31:0]             s_axi_wdata;
    logic [3:0]              s_axi_wstrb;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ADDR_WIDTH+1:0]   s_axi_araddr;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [31:0]             s_axi_rdata;
    logic [1:0]              s_axi_rresp;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

interface axi_ad7124_up_bus_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                    up_wreq;
    logic [ADDR_WIDTH-1:0]   up_waddr;
    logic [31:0]             up_wdata;
    logic                    up_wack;
    logic                    up_rreq;
    logic [ADDR_WIDTH-1:0]   up_raddr;
    logic [31:0]             up_rdata;
    logic                    up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );
endinterface

// File: rtl/axi_ad7124_up_axi.sv
// ---------------------------------------------------------------------------
// axi_ad7124_up_axi
// AXI4-Lite slave that turns every AXI write/read into a one-cycle up_wreq /
// up_rreq on the up_* register bus, waits for up_wack / up_rack and returns
// the AXI response. Regions that never acknowledge (generic sub-space, absent
// boards) are closed by a TIMEOUT-cycle watchdog that answers SLVERR.
// Write and read paths are independent FSMs: IDLE -> REQ -> WAIT -> RESP.
//
// Ports:
//   up_clk  - sole clock
//   up_rst  - synchronous reset, active-high
//   s_axi   - AXI4-Lite slave (AW/W joint handshake, B, AR, R)
//   up      - up_* bus master (wreq/waddr/wdata/wack, rreq/raddr/rdata/rack)
// ---------------------------------------------------------------------------
module axi_ad7124_up_axi #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 64
) (
    input  logic                  up_clk,
    input  logic                  up_rst,
    axi_ad7124_up_axi_if.slave    s_axi,
    axi_ad7124_up_bus_if.master   up
);

    localparam int               CNT_W       = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  wr_state_r;
    state_t                  wr_next_s;
    state_t                  rd_state_r;
    state_t                  rd_next_s;
    logic                    w_hs_s;
    logic                    r_hs_s;
    logic                    w_tmo_s;
    logic                    r_tmo_s;
    logic [CNT_W-1:0]        wcnt_r;
    logic [CNT_W-1:0]        rcnt_r;
    logic [ADDR_WIDTH-1:0]   waddr_r;
    logic [31:0]             wdata_r;
    logic [1:0]              bresp_r;
    logic [ADDR_WIDTH-1:0]   raddr_r;
    logic [31:0]             rdata_r;
    logic [1:0]              rresp_r;

    // The readies are only raised in the cycle the handshake actually happens,
    // so AW-only or W-only traffic never sees a ready.
    assign s_axi.s_axi_awready = w_hs_s;
    assign s_axi.s_axi_wready  = w_hs_s;
    assign s_axi.s_axi_bvalid  = (wr_state_r == ST_RESP);
    assign s_axi.s_axi_bresp   = bresp_r;
    assign s_axi.s_axi_arready = r_hs_s;
    assign s_axi.s_axi_rvalid  = (rd_state_r == ST_RESP);
    assign s_axi.s_axi_rdata   = rdata_r;
    assign s_axi.s_axi_rresp   = rresp_r;

    assign up.up_wreq  = (wr_state_r == ST_REQ);
    assign up.up_waddr = waddr_r;
    assign up.up_wdata = wdata_r;
    assign up.up_rreq  = (rd_state_r == ST_REQ);
    assign up.up_raddr = raddr_r;

    // Write FSM state register
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            wr_state_r <= ST_IDLE;
        end else begin
            wr_state_r <= wr_next_s;
        end
    end

    // Write FSM next state, joint AW/W handshake strobe and watchdog expiry
    always_comb begin
        wr_next_s = wr_state_r;
        w_hs_s    = 1'b0;
        w_tmo_s   = 1'b0;
        case (wr_state_r)
            ST_IDLE: begin
                if (!up_rst && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) begin
                    w_hs_s = 1'b1;
                    // Partial-word writes are refused without touching the bus.
                    if (s_axi.s_axi_wstrb == 4'hF) begin
                        wr_next_s = ST_REQ;
                    end else begin
                        wr_next_s = ST_RESP;
                    end
                end else begin
                    wr_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Any ack here belongs to an earlier request and is ignored.
                wr_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (up.up_wack) begin
                    wr_next_s = ST_RESP;
                end else if (wcnt_r == CNT_LAST) begin
                    w_tmo_s   = 1'b1;
                    wr_next_s = ST_RESP;
                end else begin
                    wr_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (s_axi.s_axi_bready) begin
                    wr_next_s = ST_IDLE;
                end else begin
                    wr_next_s = ST_RESP;
                end
            end
            default: begin
                wr_next_s = ST_IDLE;
            end
        endcase
    end

    // Write address/data capture, wait counter and response code
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            waddr_r <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 32'h0000_0000;
            bresp_r <= RESP_OKAY;
            wcnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (w_hs_s) begin
                waddr_r <= s_axi.s_axi_awaddr[ADDR_WIDTH+1:2];
                wdata_r <= s_axi.s_axi_wdata;
                bresp_r <= (s_axi.s_axi_wstrb == 4'hF) ? RESP_OKAY : RESP_SLVERR;
            end
            if (wr_state_r == ST_WAIT) begin
                wcnt_r <= wcnt_r + CNT_W'(1);
                if (up.up_wack) begin
                    bresp_r <= RESP_OKAY;
                end else if (w_tmo_s) begin
                    bresp_r <= RESP_SLVERR;
                end
            end else begin
                wcnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            rd_state_r <= ST_IDLE;
        end else begin
            rd_state_r <= rd_next_s;
        end
    end

    // Read FSM next state, AR handshake strobe and watchdog expiry
    always_comb begin
        rd_next_s = rd_state_r;
        r_hs_s    = 1'b0;
        r_tmo_s   = 1'b0;
        case (rd_state_r)
            ST_IDLE: begin
                if (!up_rst && s_axi.s_axi_arvalid) begin
                    r_hs_s    = 1'b1;
                    rd_next_s = ST_REQ;
                end else begin
                    rd_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                rd_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (up.up_rack) begin
                    rd_next_s = ST_RESP;
                end else if (rcnt_r == CNT_LAST) begin
                    r_tmo_s   = 1'b1;
                    rd_next_s = ST_RESP;
                end else begin
                    rd_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (s_axi.s_axi_rready) begin
                    rd_next_s = ST_IDLE;
                end else begin
                    rd_next_s = ST_RESP;
                end
            end
            default: begin
                rd_next_s = ST_IDLE;
            end
        endcase
    end

    // Read address capture, wait counter, read data and response code
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            raddr_r <= {ADDR_WIDTH{1'b0}};
            rdata_r <= 32'h0000_0000;
            rresp_r <= RESP_OKAY;
            rcnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (r_hs_s) begin
                raddr_r <= s_axi.s_axi_araddr[ADDR_WIDTH+1:2];
            end
            if (rd_state_r == ST_WAIT) begin
                rcnt_r <= rcnt_r + CNT_W'(1);
                if (up.up_rack) begin
                    rdata_r <= up.up_rdata;
                    rresp_r <= RESP_OKAY;
                end else if (r_tmo_s) begin
                    rdata_r <= 32'h0000_0000;
                    rresp_r <= RESP_SLVERR;
                end
            end else begin
                rcnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_axi_ad7124_up_axi.sv
// ---------------------------------------------------------------------------
// Bench for axi_ad7124_up_axi. A transaction-level model predicts, from the
// handshake cycle and the scheduled ack delay, when up_*req pulses, when the
// B/R response appears and what it carries. The register-map responder is
// driven from the same schedule. Directed scenarios pin latencies and data
// with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_axi_ad7124_up_axi;
    localparam int AW = 14;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_ad7124_up_axi_if #(.ADDR_WIDTH(AW)) axi ();
    axi_ad7124_up_bus_if #(.ADDR_WIDTH(AW)) up ();

    axi_ad7124_up_axi #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .up_clk (clk),
        .up_rst (rst),
        .s_axi  (axi),
        .up     (up)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // stimulus-side schedule for the responder
    int          w_ack_dly  = -1;
    int          r_ack_dly  = -1;
    logic [31:0] r_ack_data = 32'h0;

    // model state
    bit            m_wb = 1'b0, m_rb = 1'b0;
    logic [AW-1:0] m_waddr = '0, m_raddr = '0;
    logic [31:0]   m_wdata = '0, m_rdata = '0;
    logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
    int            m_wreq = -1, m_rreq = -1, m_bcyc = -1, m_rcyc = -1;
    int            m_w_ack = -1, m_r_ack = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: an ack counts only if it lands 1..TO cycles after the
    // request pulse; otherwise the response comes TO+2 cycles after handshake.
    always @(posedge clk) begin
        if (rst) begin
            m_wb = 1'b0; m_rb = 1'b0;
            m_waddr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
            m_bresp = 2'b00; m_rresp = 2'b00;
            m_w_ack = -1; m_r_ack = -1; m_wreq = -1; m_rreq = -1;
        end else begin
            if (!m_wb && axi.s_axi_awvalid && axi.s_axi_wvalid) begin
                m_wb    = 1'b1;
                m_waddr = axi.s_axi_awaddr[AW+1:2];
                m_wdata = axi.s_axi_wdata;
                if (axi.s_axi_wstrb == 4'hF) begin
                    m_wreq  = cyc + 1;
                    m_w_ack = (w_ack_dly >= 0) ? cyc + 1 + w_ack_dly : -1;
                    if (w_ack_dly >= 1 && w_ack_dly <= TO) begin
                        m_bcyc = cyc + 2 + w_ack_dly; m_bresp = 2'b00;
                    end else begin
                        m_bcyc = cyc + TO + 2; m_bresp = 2'b10;
                    end
                end else begin
                    m_wreq = -1; m_w_ack = -1; m_bcyc = cyc + 1; m_bresp = 2'b10;
                end
            end else if (m_wb && cyc >= m_bcyc && axi.s_axi_bready) begin
                m_wb = 1'b0;
            end
            if (!m_rb && axi.s_axi_arvalid) begin
                m_rb    = 1'b1;
                m_raddr = axi.s_axi_araddr[AW+1:2];
                m_rreq  = cyc + 1;
                m_r_ack = (r_ack_dly >= 0) ? cyc + 1 + r_ack_dly : -1;
                if (r_ack_dly >= 1 && r_ack_dly <= TO) begin
                    m_rcyc = cyc + 2 + r_ack_dly; m_rresp = 2'b00; m_rdata = r_ack_data;
                end else begin
                    m_rcyc = cyc + TO + 2; m_rresp = 2'b10; m_rdata = 32'h0;
                end
            end else if (m_rb && cyc >= m_rcyc && axi.s_axi_rready) begin
                m_rb = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // Register-map responder: acks on the scheduled cycle, garbage data otherwise
    always @(posedge clk) begin
        #1;
        up.up_wack  = (cyc == m_w_ack);
        up.up_rack  = (cyc == m_r_ack);
        up.up_rdata = (cyc == m_r_ack) ? r_ack_data : (32'hBAD0_0000 | 32'(cyc));
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            chk("awready", 32'(axi.s_axi_awready), 32'(!m_wb && axi.s_axi_awvalid && axi.s_axi_wvalid));
            chk("wready",  32'(axi.s_axi_wready),  32'(!m_wb && axi.s_axi_awvalid && axi.s_axi_wvalid));
            chk("arready", 32'(axi.s_axi_arready), 32'(!m_rb && axi.s_axi_arvalid));
            chk("up_wreq", 32'(up.up_wreq), 32'(m_wb && cyc == m_wreq));
            chk("up_rreq", 32'(up.up_rreq), 32'(m_rb && cyc == m_rreq));
            chk("up_waddr", 32'(up.up_waddr), 32'(m_waddr));
            chk("up_wdata", up.up_wdata, m_wdata);
            chk("up_raddr", 32'(up.up_raddr), 32'(m_raddr));
            chk("bvalid", 32'(axi.s_axi_bvalid), 32'(m_wb && cyc >= m_bcyc));
            chk("rvalid", 32'(axi.s_axi_rvalid), 32'(m_rb && cyc >= m_rcyc));
            if (m_wb && cyc >= m_bcyc) chk("bresp", 32'(axi.s_axi_bresp), 32'(m_bresp));
            if (m_rb && cyc >= m_rcyc) begin
                chk("rresp", 32'(axi.s_axi_rresp), 32'(m_rresp));
                chk("rdata", axi.s_axi_rdata, m_rdata);
            end
        end
    end

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int dly, input int aw_lead, input int hold,
                            output int lat, output logic [1:0] resp, output logic [AW-1:0] ad);
        int t0;
        bit got;
        t0 = 0; lat = -1; resp = 2'b11; ad = '1;
        w_ack_dly = dly;
        @(posedge clk); #1;
        axi.s_axi_awaddr = addr; axi.s_axi_wdata = data; axi.s_axi_wstrb = strb;
        axi.s_axi_awvalid = 1'b1;
        repeat (aw_lead) begin @(posedge clk); #1; end
        axi.s_axi_wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (axi.s_axi_awready === 1'b1 && axi.s_axi_wready === 1'b1) begin got = 1'b1; t0 = cyc; end
        end
        chk("aw_w_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < TO + 20 && !got; i++) begin
            @(negedge clk);
            if (axi.s_axi_bvalid === 1'b1) begin
                got = 1'b1; lat = cyc - t0; resp = axi.s_axi_bresp; ad = up.up_waddr;
            end
        end
        chk("b_response_seen", 32'(got), 32'd1);
        repeat (hold) @(posedge clk);
        #1; axi.s_axi_bready = 1'b1;
        @(posedge clk); #1; axi.s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] data, input int dly, input int hold,
                           output int lat, output logic [1:0] resp, output logic [31:0] rd,
                           output logic [AW-1:0] ad);
        int t0;
        bit got;
        t0 = 0; lat = -1; resp = 2'b11; rd = 32'hFFFF_FFFF; ad = '1;
        r_ack_dly = dly; r_ack_data = data;
        @(posedge clk); #1;
        axi.s_axi_araddr = addr; axi.s_axi_arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (axi.s_axi_arready === 1'b1) begin got = 1'b1; t0 = cyc; end
        end
        chk("ar_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        axi.s_axi_arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < TO + 20 && !got; i++) begin
            @(negedge clk);
            if (axi.s_axi_rvalid === 1'b1) begin
                got = 1'b1; lat = cyc - t0; resp = axi.s_axi_rresp; rd = axi.s_axi_rdata; ad = up.up_raddr;
            end
        end
        chk("r_response_seen", 32'(got), 32'd1);
        repeat (hold) @(posedge clk);
        #1; axi.s_axi_rready = 1'b1;
        @(posedge clk); #1; axi.s_axi_rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, lat2;
        logic [1:0]    resp, resp2;
        logic [31:0]   rd;
        logic [AW-1:0] ad, ad2;
        bit            got;

        axi.s_axi_awvalid = 1'b0; axi.s_axi_awaddr = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_wdata = 32'h0; axi.s_axi_wstrb = 4'h0; axi.s_axi_bready = 1'b0;
        axi.s_axi_arvalid = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_rready = 1'b0;
        up.up_wack = 1'b0; up.up_rack = 1'b0; up.up_rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_bvalid",   32'(axi.s_axi_bvalid), 32'd0);
        chk("reset_rvalid",   32'(axi.s_axi_rvalid), 32'd0);
        chk("reset_rdata",    axi.s_axi_rdata, 32'h0);
        chk("reset_up_waddr", 32'(up.up_waddr), 32'd0);
        chk("reset_up_wreq",  32'(up.up_wreq), 32'd0);

        // acked write, ack one cycle after the request pulse
        do_write(16'h0900, 32'h1234_5678, 4'hF, 1, 0, 1, lat, resp, ad);
        chk("wr_ok_latency", 32'(lat), 32'd3);
        chk("wr_ok_bresp", 32'(resp), 32'd0);
        chk("wr_ok_waddr", 32'(ad), 32'h240);

        // acked read, ack three cycles after the request pulse
        do_read(16'h0D04, 32'hCAFE_0001, 3, 1, lat, resp, rd, ad);
        chk("rd_ok_rdata", rd, 32'hCAFE_0001);
        chk("rd_ok_rresp", 32'(resp), 32'd0);
        chk("rd_ok_latency", 32'(lat), 32'd5);
        chk("rd_ok_raddr", 32'(ad), 32'h341);

        // generic region: never acked -> timeout
        do_write(16'h0000, 32'hA5A5_A5A5, 4'hF, -1, 0, 1, lat, resp, ad);
        chk("wr_tmo_latency", 32'(lat), 32'd18);
        chk("wr_tmo_bresp", 32'(resp), 32'd2);
        do_read(16'h0000, 32'h5555_AAAA, -1, 1, lat, resp, rd, ad);
        chk("rd_tmo_latency", 32'(lat), 32'd18);
        chk("rd_tmo_rresp", 32'(resp), 32'd2);
        chk("rd_tmo_rdata", rd, 32'h0);

        // partial strobe with AW leading W by five cycles
        do_write(16'h0A08, 32'h0000_00FF, 4'h3, 1, 5, 1, lat, resp, ad);
        chk("wr_strb_latency", 32'(lat), 32'd1);
        chk("wr_strb_bresp", 32'(resp), 32'd2);

        // ack only during the request cycle is ignored -> timeout
        do_write(16'h0904, 32'h0F0F_0F0F, 4'hF, 0, 0, 1, lat, resp, ad);
        chk("wr_reqack_latency", 32'(lat), 32'd18);
        chk("wr_reqack_bresp", 32'(resp), 32'd2);

        // late ack lands while the timeout response waits for rready
        do_read(16'h0D08, 32'h7777_0000, TO + 2, 4, lat, resp, rd, ad);
        chk("rd_late_rdata", rd, 32'h0);
        chk("rd_late_rresp", 32'(resp), 32'd2);
        do_read(16'h0D0C, 32'h1357_2468, 2, 1, lat, resp, rd, ad);
        chk("rd_after_late_latency", 32'(lat), 32'd4);
        chk("rd_after_late_rdata", rd, 32'h1357_2468);

        // concurrent write and read, responses held for ten cycles
        fork
            do_write(16'h0910, 32'hDEAD_BEEF, 4'hF, 2, 0, 10, lat, resp, ad);
            do_read(16'h0D10, 32'h0BAD_F00D, 1, 10, lat2, resp2, rd, ad2);
        join
        chk("conc_wr_latency", 32'(lat), 32'd4);
        chk("conc_wr_bresp", 32'(resp), 32'd0);
        chk("conc_rd_latency", 32'(lat2), 32'd3);
        chk("conc_rd_rdata", rd, 32'h0BAD_F00D);

        // reset in the middle of a read wait
        r_ack_dly = -1;
        @(posedge clk); #1;
        axi.s_axi_araddr = 16'h0D14; axi.s_axi_arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (axi.s_axi_arready === 1'b1) got = 1'b1;
        end
        chk("rst_ar_handshake", 32'(got), 32'd1);
        @(posedge clk); #1; axi.s_axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
        chk("midrst_up_raddr", 32'(up.up_raddr), 32'd0);
        chk("midrst_up_rreq", 32'(up.up_rreq), 32'd0);
        do_read(16'h0D18, 32'h2468_ACE0, 1, 1, lat, resp, rd, ad);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rresp", 32'(resp), 32'd0);
        chk("post_rst_rdata", rd, 32'h2468_ACE0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
